// File: rtl/coffee_order_ctrl_if.sv
// Signal bundle between the order/payment front end and its surroundings.
// The slave side is the controller; the master side is coin/button/brew-FSM logic.
interface coffee_order_ctrl_if #(
   parameter int CREDIT_W = 4
);
   logic                coin_valid;
   logic [1:0]          coin_val;
   logic                sel_valid;
   logic [1:0]          sel_in;
   logic                cancel;
   logic                brew_done;
   logic                start;
   logic [1:0]          coffee_sel;
   logic [CREDIT_W-1:0] credit;
   logic                coin_reject;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                busy;
   logic [2:0]          dbg_state;

   // All controller outputs are registered or decoded from registered state;
   // pulses (start, coin_reject, change_valid) are high for exactly one cycle.
   modport master (
      output coin_valid, coin_val, sel_valid, sel_in, cancel, brew_done,
      input  start, coffee_sel, credit, coin_reject, change_valid, change_amt,
             busy, dbg_state
   );

   modport slave (
      input  coin_valid, coin_val, sel_valid, sel_in, cancel, brew_done,
      output start, coffee_sel, credit, coin_reject, change_valid, change_amt,
             busy, dbg_state
   );
endinterface

// File: rtl/coffee_order_ctrl.sv
// Coin credit / drink selection controller in front of the coffee sequencer:
// issues a start pulse once credit covers the price, then returns change.
module coffee_order_ctrl #(
   parameter int PRICE_E     = 4,
   parameter int PRICE_L     = 6,
   parameter int PRICE_C     = 7,
   parameter int CREDIT_W    = 4,
   parameter int TIMEOUT_CYC = 20,
   parameter int TIMEOUT_W   = 5
) (
   input logic               clk,
   input logic               reset_n,
   coffee_order_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      START   = 3'd2,
      BREW    = 3'd3,
      CHANGE  = 3'd4,
      REFUND  = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic                 sel_latched_q, sel_latched_d;
   logic [1:0]           coffee_sel_q, coffee_sel_d;
   logic                 coin_reject_q, coin_reject_d;
   logic                 change_valid_q, change_valid_d;
   logic [CREDIT_W-1:0]  change_amt_q, change_amt_d;
   logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;

   logic [CREDIT_W-1:0]  price;
   logic [CREDIT_W-1:0]  coin_units;
   logic [CREDIT_W:0]    coin_sum;
   logic                 coin_ok;
   logic [CREDIT_W-1:0]  change_calc;

   always_comb begin
      case (coffee_sel_q)
         2'b00:   price = CREDIT_W'(PRICE_E);
         2'b01:   price = CREDIT_W'(PRICE_L);
         default: price = CREDIT_W'(PRICE_C);
      endcase
      case (bus.coin_val)
         2'b00:   coin_units = CREDIT_W'(1);
         2'b01:   coin_units = CREDIT_W'(2);
         2'b10:   coin_units = CREDIT_W'(5);
         default: coin_units = '0;
      endcase
   end

   // The extra sum bit flags credit overflow.
   assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_units};
   assign coin_ok     = bus.coin_valid && (bus.coin_val != 2'b11) && !coin_sum[CREDIT_W];
   assign change_calc = credit_q - price;

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      sel_latched_d  = sel_latched_q;
      coffee_sel_d   = coffee_sel_q;
      coin_reject_d  = 1'b0;
      change_valid_d = 1'b0;
      change_amt_d   = change_amt_q;
      tcnt_d         = '0;

      case (state_q)
         IDLE, COLLECT: begin
            if (bus.cancel || (state_q == COLLECT && !bus.coin_valid && !bus.sel_valid &&
                               tcnt_q == TIMEOUT_W'(TIMEOUT_CYC))) begin
               // Cancel and inactivity timeout share the refund path.
               coin_reject_d = bus.coin_valid;
               sel_latched_d = 1'b0;
               if (credit_q != '0) begin
                  state_d        = REFUND;
                  change_valid_d = 1'b1;
                  change_amt_d   = credit_q;
                  credit_d       = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (state_q == COLLECT && sel_latched_q && credit_q >= price) begin
               // Order is committed; late coins are returned, late buttons ignored.
               state_d       = START;
               coin_reject_d = bus.coin_valid;
            end else begin
               if (bus.coin_valid) begin
                  if (coin_ok) begin
                     credit_d = coin_sum[CREDIT_W-1:0];
                     state_d  = COLLECT;
                  end else begin
                     coin_reject_d = 1'b1;
                  end
               end
               if (bus.sel_valid && bus.sel_in != 2'b11) begin
                  coffee_sel_d  = bus.sel_in;
                  sel_latched_d = 1'b1;
                  state_d       = COLLECT;
               end
               if (state_q == COLLECT && !bus.coin_valid && !bus.sel_valid)
                  tcnt_d = tcnt_q + 1'b1;
            end
         end
         START: begin
            state_d       = BREW;
            coin_reject_d = bus.coin_valid;
         end
         BREW: begin
            coin_reject_d = bus.coin_valid;
            if (bus.brew_done) begin
               state_d       = CHANGE;
               credit_d      = '0;
               sel_latched_d = 1'b0;
               // A zero change leaves the previous change_amt in place.
               if (change_calc != '0) begin
                  change_valid_d = 1'b1;
                  change_amt_d   = change_calc;
               end
            end
         end
         CHANGE, REFUND: begin
            state_d       = IDLE;
            coin_reject_d = bus.coin_valid;
         end
         default: begin
            state_d       = IDLE;
            credit_d      = '0;
            sel_latched_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         sel_latched_q  <= 1'b0;
         coffee_sel_q   <= 2'b00;
         coin_reject_q  <= 1'b0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
         tcnt_q         <= '0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         sel_latched_q  <= sel_latched_d;
         coffee_sel_q   <= coffee_sel_d;
         coin_reject_q  <= coin_reject_d;
         change_valid_q <= change_valid_d;
         change_amt_q   <= change_amt_d;
         tcnt_q         <= tcnt_d;
      end
   end

   assign bus.start        = (state_q == START);
   assign bus.busy         = (state_q == START) || (state_q == BREW) || (state_q == CHANGE);
   assign bus.coffee_sel   = coffee_sel_q;
   assign bus.credit       = credit_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_amt   = change_amt_q;
   assign bus.dbg_state    = state_q;
endmodule
